// File: rtl/cmp_pkg.sv
// Shared comparator definitions: relation encoding and result decode.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_EQ = 3'd0,
        CMP_NE = 3'd1,
        CMP_LT = 3'd2,
        CMP_LE = 3'd3,
        CMP_GT = 3'd4,
        CMP_GE = 3'd5
    } cmp_mode_t;

    // Encodings 6/7 are reserved and always decode to 0.
    function automatic logic cmp_decode(input logic [2:0] mode, input logic lt, input logic eq);
        logic res;
        res = 1'b0;
        case (mode)
            CMP_EQ:  res = eq;
            CMP_NE:  res = !eq;
            CMP_LT:  res = lt;
            CMP_LE:  res = lt | eq;
            CMP_GT:  res = !(lt | eq);
            CMP_GE:  res = !lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_pipe_stage.sv
// Purpose: generic valid/ready register slice carrying a W-bit payload.
// Latency: 1 cycle; full throughput.
// Backpressure: holds payload while out_rdy is low; in_rdy = !out_vld || out_rdy.
module cmp_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/cmp_pipe.sv
// Purpose: pipelined EQ/NE/LT/LE/GT/GE comparator, signed or unsigned per transaction.
// Latency: 2 cycles input accept to O_VALID, 1 result/cycle; capacity 2 transactions.
// Backpressure: combinational ready chain, I_READY low only when both stages are full.
// Optional: CMP_PIPE_MATCH_CNT_EN adds CNT_CLR / MATCH_CNT (saturating count of true results).
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
`ifdef CMP_PIPE_MATCH_CNT_EN
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] MATCH_CNT,
`endif
    input  logic [N-1:0]     I0,
    input  logic [N-1:0]     I1,
    input  logic [2:0]       MODE,
    input  logic             SIGNED,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic             O,
    output logic             O_VALID,
    input  logic             O_READY
);

    typedef struct packed {
        logic [N:0] d;      // I0 - I1 with carry-out in bit N
        logic       a_msb;
        logic       b_msb;
        logic [2:0] mode;
        logic       sgn;
    } s1_t;

    s1_t  s1_in;
    s1_t  s1_q;
    logic s1_vld;
    logic adv2;
    logic eq, lt, v, res;

    always_comb begin
        s1_in.d     = {1'b0, I0} + {1'b0, ~I1} + (N+1)'(1);
        s1_in.a_msb = I0[N-1];
        s1_in.b_msb = I1[N-1];
        s1_in.mode  = MODE;
        s1_in.sgn   = SIGNED;
    end

    cmp_pipe_stage #(.W($bits(s1_t))) u_s1 (
        .clk     (CLK),
        .reset   (RESET),
        .in_vld  (I_VALID),
        .in_dat  (s1_in),
        .in_rdy  (I_READY),
        .out_vld (s1_vld),
        .out_dat (s1_q),
        .out_rdy (adv2)
    );

    // Only the carry bit and the overflow term decide LT, so N-bit wrap of d is harmless.
    always_comb begin
        eq  = (s1_q.d[N-1:0] == '0);
        v   = (s1_q.a_msb != s1_q.b_msb) && (s1_q.d[N-1] != s1_q.a_msb);
        lt  = s1_q.sgn ? (s1_q.d[N-1] ^ v) : !s1_q.d[N];
        res = cmp_decode(s1_q.mode, lt, eq);
    end

    cmp_pipe_stage #(.W(1)) u_s2 (
        .clk     (CLK),
        .reset   (RESET),
        .in_vld  (s1_vld),
        .in_dat  (res),
        .in_rdy  (adv2),
        .out_vld (O_VALID),
        .out_dat (O),
        .out_rdy (O_READY)
    );

`ifdef CMP_PIPE_MATCH_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET || CNT_CLR) begin
            MATCH_CNT <= '0;
        end else if (O_VALID && O_READY && O && (MATCH_CNT != '1)) begin
            MATCH_CNT <= MATCH_CNT + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the counter; keep it referenced so the parameter list is uniform.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
